// File: rtl/sata_speed_negotiator.sv
`default_nettype none
// ============================================================================
// Module   : sata_speed_negotiator
// Brief    : Drives OOB reset, line-rate selection, PLL-lock wait and link-up
//            timing; falls back Gen2<->Gen1 and filters/counts link drops.
//            Optional post-drop HOLD state: define SPEED_NEG_HOLDOFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sata_speed_negotiator #(
    parameter int          RESET_CYC = 16,
    parameter logic [23:0] LINK_TMO  = 24'd2000000,
    parameter int          MAX_TRIES = 4,
    parameter int          LOSS_FILT = 32,
    parameter int          HOLDOFF   = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_locked,
    input  logic       linkup,
    input  logic       rxelecidle,
    input  logic       rate_ack,
    output logic       oob_reset,
    output logic       gen2,
    output logic       rate_req,
    output logic       link_up,
    output logic [2:0] try_cnt,
    output logic [7:0] drop_cnt,
    output logic [2:0] neg_state
);

    localparam logic [2:0]  c_st_reset   = 3'd0;
    localparam logic [2:0]  c_st_rate    = 3'd1;
    localparam logic [2:0]  c_st_pll     = 3'd2;
    localparam logic [2:0]  c_st_train   = 3'd3;
    localparam logic [2:0]  c_st_up      = 3'd4;
    localparam logic [2:0]  c_st_loss    = 3'd5;
`ifdef SPEED_NEG_HOLDOFF_EN
    localparam logic [2:0]  c_st_hold    = 3'd6;
    localparam int          c_hold_w     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLDOFF - 1);
`endif
    localparam logic [23:0] c_reset_last = 24'(RESET_CYC - 1);
    localparam logic [23:0] c_tmo_last   = LINK_TMO - 24'd1;
    localparam logic [23:0] c_filt_last  = 24'(LOSS_FILT - 1);
    localparam logic [2:0]  c_tries_last = 3'(MAX_TRIES - 1);

    generate
        if (RESET_CYC < 2 || MAX_TRIES < 1 || MAX_TRIES > 8 || LOSS_FILT < 1 || HOLDOFF < 1) begin : g_param_check
            $error("sata_speed_negotiator: parameter out of range");
        end
    endgenerate

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [23:0] r_timer;
    logic        r_rate_pend;
    logic        w_loss_cond;
    logic        w_timeout;
    logic        w_drop;
    logic        w_oob_reset;
    logic        w_rate_req;
    logic        w_link_up;
`ifdef SPEED_NEG_HOLDOFF_EN
    logic [c_hold_w-1:0] r_hold_cnt;
`endif

    assign w_loss_cond = ~linkup | rxelecidle;
    assign neg_state   = r_state;

    // The shared timer serves RESET/TRAIN and doubles as the loss filter in UP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_reset;
            r_timer     <= '0;
            r_rate_pend <= 1'b1;
            oob_reset   <= 1'b1;
            gen2        <= 1'b1;
            rate_req    <= 1'b0;
            link_up     <= 1'b0;
            try_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            r_state   <= w_next;
            oob_reset <= w_oob_reset;
            rate_req  <= w_rate_req;
            link_up   <= w_link_up;

            if (w_next != r_state)
                r_timer <= '0;
            else if (r_state == c_st_up && !w_loss_cond)
                r_timer <= '0;
            else if (r_state == c_st_reset || r_state == c_st_train || r_state == c_st_up)
                r_timer <= r_timer + 24'd1;

            if (w_timeout) begin
                if (try_cnt == c_tries_last) begin
                    gen2        <= ~gen2;
                    try_cnt     <= '0;
                    r_rate_pend <= 1'b1;
                end else begin
                    try_cnt <= try_cnt + 3'd1;
                end
            end else if (w_next == c_st_up && r_state != c_st_up) begin
                try_cnt <= '0;
            end

            if (r_state == c_st_rate && rate_ack)
                r_rate_pend <= 1'b0;

            if (w_drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef SPEED_NEG_HOLDOFF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_hold_cnt <= '0;
        else if (r_state == c_st_hold && w_next == c_st_hold)
            r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
        else
            r_hold_cnt <= '0;
    end
`endif

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            c_st_reset: if (r_timer == c_reset_last) w_next = r_rate_pend ? c_st_rate : c_st_pll;
            c_st_rate:  if (rate_ack) w_next = c_st_pll;
            c_st_pll:   if (rx_locked) w_next = c_st_train;
            c_st_train: begin
                // Lock loss beats linkup, and linkup beats the timeout.
                if (!rx_locked) begin
                    w_next = c_st_reset;
                end else if (linkup) begin
                    w_next = c_st_up;
                end else if (r_timer == c_tmo_last) begin
                    w_next    = c_st_reset;
                    w_timeout = 1'b1;
                end
            end
            c_st_up: begin
                if (!rx_locked) begin
                    w_next = c_st_reset;
                    w_drop = 1'b1;
                end else if (w_loss_cond && r_timer == c_filt_last) begin
                    w_next = c_st_loss;
                end
            end
            c_st_loss: begin
                w_drop = 1'b1;
`ifdef SPEED_NEG_HOLDOFF_EN
                w_next = c_st_hold;
`else
                w_next = c_st_reset;
`endif
            end
`ifdef SPEED_NEG_HOLDOFF_EN
            c_st_hold:  if (r_hold_cnt == c_hold_last) w_next = c_st_reset;
`endif
            default:    w_next = c_st_reset;
        endcase
    end

    always_comb begin
        w_oob_reset = 1'b1;
        w_rate_req  = 1'b0;
        w_link_up   = 1'b0;
        case (w_next)
            c_st_rate:  w_rate_req = 1'b1;
            c_st_train: w_oob_reset = 1'b0;
            c_st_up: begin
                w_oob_reset = 1'b0;
                w_link_up   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sata_speed_negotiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sata_speed_negotiator
// Brief    : Scripted and $urandom stimulus against a cycle-level phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sata_speed_negotiator;

    localparam int RESET_CYC = 4;
    localparam int LINK_TMO  = 100;
    localparam int MAX_TRIES = 2;
    localparam int LOSS_FILT = 8;
    localparam int HOLDOFF   = 20;
`ifdef SPEED_NEG_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic [17:0] RST_VEC = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};

    localparam int M_NORMAL = 0;
    localparam int M_NOLINK = 1;
    localparam int M_EDGE   = 2;
    localparam int M_FAST   = 3;
    localparam int M_RAND   = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_locked;
    logic       linkup;
    logic       rxelecidle;
    logic       rate_ack;
    logic       oob_reset;
    logic       gen2;
    logic       rate_req;
    logic       link_up;
    logic [2:0] try_cnt;
    logic [7:0] drop_cnt;
    logic [2:0] neg_state;

    sata_speed_negotiator #(
        .RESET_CYC (RESET_CYC),
        .LINK_TMO  (24'(LINK_TMO)),
        .MAX_TRIES (MAX_TRIES),
        .LOSS_FILT (LOSS_FILT),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_locked  (rx_locked),
        .linkup     (linkup),
        .rxelecidle (rxelecidle),
        .rate_ack   (rate_ack),
        .oob_reset  (oob_reset),
        .gen2       (gen2),
        .rate_req   (rate_req),
        .link_up    (link_up),
        .try_cnt    (try_cnt),
        .drop_cnt   (drop_cnt),
        .neg_state  (neg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase number plus "cycles spent" counters.
    int m_phase, m_age, m_bad, m_tries, m_drops, m_drop_events = 0;
    bit m_gen2, m_pend;

    int mode = M_NORMAL;
    int ei_force = 0;
    bit lk_kill = 1'b0;
    int rq_age = 0;
    int lu_pct = 3;
    int rq_rises = 0;
    bit rq_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_bad = 0; m_tries = 0; m_drops = 0;
        m_gen2 = 1'b1; m_pend = 1'b1;
    endtask

    task automatic model_step(input bit lk, input bit lu, input bit ei, input bit ak);
        int nxt;
        bit drop;
        nxt  = m_phase;
        drop = 1'b0;
        case (m_phase)
            0: begin
                m_age++;
                if (m_age == RESET_CYC) nxt = m_pend ? 1 : 2;
            end
            1: if (ak) begin nxt = 2; m_pend = 1'b0; end
            2: if (lk) nxt = 3;
            3: begin
                m_age++;
                if (!lk) nxt = 0;
                else if (lu) begin nxt = 4; m_tries = 0; end
                else if (m_age == LINK_TMO) begin
                    nxt = 0;
                    m_tries++;
                    if (m_tries == MAX_TRIES) begin
                        m_tries = 0; m_gen2 = !m_gen2; m_pend = 1'b1;
                    end
                end
            end
            4: begin
                if (!lk) begin nxt = 0; drop = 1'b1; end
                else begin
                    m_bad = (!lu || ei) ? m_bad + 1 : 0;
                    if (m_bad == LOSS_FILT) nxt = 5;
                end
            end
            5: begin drop = 1'b1; nxt = HOLD_EN ? 6 : 0; end
            default: begin
                m_age++;
                if (m_age == HOLDOFF) nxt = 0;
            end
        endcase
        if (drop) begin
            m_drop_events++;
            if (m_drops < 255) m_drops++;
        end
        if (nxt != m_phase) begin m_age = 0; m_bad = 0; end
        m_phase = nxt;
    endtask

    function automatic logic [17:0] model_vec();
        return {3'(m_phase), !(m_phase == 3 || m_phase == 4), m_gen2, (m_phase == 1),
                (m_phase == 4), 3'(m_tries), 8'(m_drops)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {neg_state, oob_reset, gen2, rate_req, link_up, try_cnt, drop_cnt};
    endfunction

    function automatic int dut_field(input int sel);
        case (sel)
            0: return int'(neg_state);
            1: return int'(link_up);
            2: return int'(gen2);
            3: return int'(try_cnt);
            4: return int'(rate_req);
            default: return int'(drop_cnt);
        endcase
    endfunction

    task automatic drive();
        bit lk, lu, ei, ak;
        lk = 1'b1; lu = 1'b0; ei = 1'b0; ak = 1'b0;
        if (m_phase == 1) begin rq_age++; ak = (rq_age == 3); end
        else rq_age = 0;
        case (mode)
            M_NORMAL: lu = (m_phase == 3 && m_age >= 50) || m_phase == 4;
            M_NOLINK: lu = 1'b0;
            M_EDGE:   lu = (m_phase == 3 && m_age == LINK_TMO - 1) || m_phase == 4;
            M_FAST: begin
                lu = (m_phase == 3 && m_age >= 2);
                lk = !(m_phase == 4 && $urandom_range(0, 15) == 0);
            end
            default: begin
                lk = ($urandom_range(0, 63) != 0);
                lu = ($urandom_range(0, 3) < lu_pct);
                ei = ($urandom_range(0, 7) == 0);
                ak = ak || ($urandom_range(0, 7) == 0);
            end
        endcase
        if (ei_force > 0) begin ei = 1'b1; ei_force--; end
        if (lk_kill) begin lk = 1'b0; lk_kill = 1'b0; end
        rx_locked = lk; linkup = lu; rxelecidle = ei; rate_ack = ak;
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step(rx_locked, linkup, rxelecidle, rate_ack);
        @(negedge clk);
        chk("cycle", 32'(dut_vec()), 32'(model_vec()));
        if (rate_req && !rq_prev) rq_rises++;
        rq_prev = rate_req;
    endtask

    task automatic wait_for(input int sel, input int val, input int budget, input string tag);
        int n;
        n = 0;
        while (dut_field(sel) != val && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(dut_field(sel)), 32'(val));
    endtask

    initial begin
        int n;
        int start;
        rx_locked = 1'b0; linkup = 1'b0; rxelecidle = 1'b0; rate_ack = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #2 chk("reset_vals", 32'(dut_vec()), 32'(RST_VEC));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Normal bring-up at Gen2
        n = 0;
        do begin cycle(); n++; end while (neg_state == 3'd0 && n < 50);
        chk("reset_len", 32'(n), 32'(RESET_CYC));
        wait_for(1, 1, 300, "first_link");
        chk("up_gen2", 32'(gen2), 32'd1);
        chk("up_try", 32'(try_cnt), 32'd0);
        chk("rate_req_pulses", 32'(rq_rises), 32'd1);
        repeat (10) cycle();

        // Loss filter: 7 idle cycles tolerated, 8 declare a drop
        ei_force = 7;
        repeat (20) cycle();
        chk("no_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("no_drop_state", 32'(neg_state), 32'd4);
        ei_force = 8;
        wait_for(0, 5, 20, "loss_entry");
        cycle();
        n = 0;
        while (neg_state == 3'd6 && n < 40) begin n++; cycle(); end
        chk("holdoff_len", 32'(n), HOLD_EN ? 32'(HOLDOFF) : 32'd0);
        chk("restart_state", 32'(neg_state), 32'd0);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("gen2_kept", 32'(gen2), 32'd1);
        wait_for(1, 1, 300, "relink");
        chk("no_new_rate_req", 32'(rq_rises), 32'd1);

        // Speed fallback after MAX_TRIES timeouts
        mode = M_NOLINK;
        ei_force = 8;
        wait_for(0, 5, 30, "loss2");
        wait_for(3, 1, 400, "try_first");
        chk("gen2_first", 32'(gen2), 32'd1);
        wait_for(2, 0, 400, "gen2_fallback");
        chk("try_cleared", 32'(try_cnt), 32'd0);
        wait_for(4, 1, 20, "rate_req_again");
        mode = M_NORMAL;
        wait_for(1, 1, 400, "gen1_link");
        chk("gen1_speed", 32'(gen2), 32'd0);

        // linkup on the timeout cycle wins
        mode = M_EDGE;
        ei_force = 8;
        wait_for(0, 5, 30, "loss3");
        wait_for(1, 1, 400, "edge_link");
        chk("edge_try", 32'(try_cnt), 32'd0);

        // Lock loss in TRAIN
        mode = M_NOLINK;
        ei_force = 8;
        wait_for(0, 3, 100, "train_again");
        repeat (10) cycle();
        lk_kill = 1'b1;
        cycle();
        chk("lockloss_state", 32'(neg_state), 32'd0);
        chk("lockloss_try", 32'(try_cnt), 32'd0);

        // Asynchronous reset while UP
        mode = M_NORMAL;
        wait_for(1, 1, 400, "up_again");
        repeat (5) cycle();
        #2 reset_n = 1'b0;
        #1 chk("async_rst", 32'(dut_vec()), 32'(RST_VEC));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Drop counter saturation
        mode = M_FAST;
        start = m_drop_events;
        n = 0;
        while (m_drop_events - start < 260 && n < 30000) begin cycle(); n++; end
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Random traffic
        mode = M_RAND;
        repeat (6) begin
            lu_pct = $urandom_range(0, 3);
            repeat (500) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
